// File: rtl/cache_ram_if_if.sv
// Cache-side request/response and SRAM-side access bundle for cache_ram_if.
// slave = bridge view, master = the cache plus the SRAM that surround it.
interface cache_ram_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
);
  logic                             rd_req_i;
  logic [2:0]                       rd_type_i;
  logic [ADDR_WIDTH-1:0]            rd_addr_i;
  logic                             rd_rdy_o;
  logic [DATA_WIDTH-1:0]            rd_data_o;
  logic                             rd_valid_o;
  logic                             rd_last_o;
  logic                             wr_req_i;
  logic [2:0]                       wr_type_i;
  logic [DATA_WIDTH/8-1:0]          wr_en_i;
  logic [ADDR_WIDTH-1:0]            wr_addr_i;
  logic [LINE_WORDS*DATA_WIDTH-1:0] wr_data_i;
  logic                             wr_rdy_o;
  logic                             mem_ce_o;
  logic [DATA_WIDTH/8-1:0]          mem_we_o;
  logic [ADDR_WIDTH-1:0]            mem_addr_o;
  logic [DATA_WIDTH-1:0]            mem_wdata_o;
  logic [DATA_WIDTH-1:0]            mem_rdata_i;

  modport slave (
    input  rd_req_i, rd_type_i, rd_addr_i,
    input  wr_req_i, wr_type_i, wr_en_i, wr_addr_i, wr_data_i,
    input  mem_rdata_i,
    output rd_rdy_o, rd_data_o, rd_valid_o, rd_last_o, wr_rdy_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output rd_req_i, rd_type_i, rd_addr_i,
    output wr_req_i, wr_type_i, wr_en_i, wr_addr_i, wr_data_i,
    output mem_rdata_i,
    input  rd_rdy_o, rd_data_o, rd_valid_o, rd_last_o, wr_rdy_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/cache_ram_if.sv
// Cache-to-SRAM bridge: one read or write at a time, lines split into word beats; read accepted at T
// returns T+2..T+N+1, write at T completes by T+N+1; requests wait while rdy is low, write wins ties.
module cache_ram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic clk,
  input  logic rst_n,
  cache_ram_if_if.slave bus
);
  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [2:0]            TYPE_LINE = 3'b100;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(BW - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS * BW - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(BW);
  localparam logic [CW-1:0]         LAST_LINE = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RD, RD_LAST, WR} state_t;

  state_t                           state_q;
  logic [CW-1:0]                    beat_q;
  logic [CW-1:0]                    last_q;
  logic [CW-1:0]                    rbeat_q;
  logic                             rvld_q;
  logic                             ce_q;
  logic [BW-1:0]                    we_q;
  logic [ADDR_WIDTH-1:0]            addr_q;
  logic [DATA_WIDTH-1:0]            wdata_q;
  logic [LINE_WORDS*DATA_WIDTH-1:0] payload_q;

  logic                  rd_line, wr_line, rd_acc, wr_acc, beat_end;
  logic [ADDR_WIDTH-1:0] rd_base, wr_base;
  logic [DATA_WIDTH-1:0] next_word_d;

  assign rd_line  = (bus.rd_type_i == TYPE_LINE);
  assign wr_line  = (bus.wr_type_i == TYPE_LINE);
  assign rd_base  = bus.rd_addr_i & (rd_line ? LINE_MASK : WORD_MASK);
  assign wr_base  = bus.wr_addr_i & (wr_line ? LINE_MASK : WORD_MASK);
  assign wr_acc   = (state_q == IDLE) && bus.wr_req_i;
  assign rd_acc   = (state_q == IDLE) && bus.rd_req_i && !bus.wr_req_i;
  assign beat_end = (beat_q == last_q);

  // Only line writes have more than one beat, so the next word is always indexed by beat+1.
  always_comb begin
    next_word_d = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (CW'(k) == beat_q + CW'(1)) next_word_d = payload_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      last_q    <= '0;
      rbeat_q   <= '0;
      rvld_q    <= 1'b0;
      ce_q      <= 1'b0;
      we_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      payload_q <= '0;
    end else begin
      rvld_q  <= (state_q == RD);
      rbeat_q <= beat_q;
      case (state_q)
        IDLE: begin
          if (wr_acc) begin
            state_q   <= WR;
            beat_q    <= '0;
            last_q    <= wr_line ? LAST_LINE : '0;
            payload_q <= bus.wr_data_i;
            ce_q      <= 1'b1;
            addr_q    <= wr_base;
            we_q      <= wr_line ? '1 : bus.wr_en_i;
            wdata_q   <= bus.wr_data_i[DATA_WIDTH-1:0];
          end else if (rd_acc) begin
            state_q <= RD;
            beat_q  <= '0;
            last_q  <= rd_line ? LAST_LINE : '0;
            ce_q    <= 1'b1;
            addr_q  <= rd_base;
            we_q    <= '0;
            wdata_q <= '0;
          end
        end
        RD: begin
          if (beat_end) begin
            state_q <= RD_LAST;
            ce_q    <= 1'b0;
            addr_q  <= '0;
          end else begin
            beat_q <= beat_q + CW'(1);
            addr_q <= addr_q + STRIDE;
          end
        end
        RD_LAST: state_q <= IDLE;
        WR: begin
          if (beat_end) begin
            state_q <= IDLE;
            ce_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
          end else begin
            beat_q  <= beat_q + CW'(1);
            addr_q  <= addr_q + STRIDE;
            wdata_q <= next_word_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rd_rdy_o    = (state_q == IDLE) && rst_n && !bus.wr_req_i;
  assign bus.wr_rdy_o    = (state_q == IDLE) && rst_n;
  assign bus.rd_valid_o  = rvld_q;
  assign bus.rd_data_o   = rvld_q ? bus.mem_rdata_i : '0;
  assign bus.rd_last_o   = rvld_q && (rbeat_q == last_q);
  assign bus.mem_ce_o    = ce_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
endmodule
